ether_tx_arb: RTL and testbench

Two-input, packet-granular round-robin arbiter that shares the single 512-bit CMAC TX stream between two packet sources, for example the application TX path and a loopback/ARP responder. It grants one requester per packet, holds the grant until that requester's EOP beat is accepted, and forwards beats through one output register with ready/valid backpressure from the MAC. It sits directly in front of the CMAC TX interface, mirroring the position of the RX-side header stripper.

---
 rtl/ether_tx_arb.sv | 171 +++++++++++++++++
 tb/tb_ether_tx_arb.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ether_tx_arb.sv
// Two-input, packet-granular round-robin arbiter in front of the CMAC TX
// stream. One requester owns the output from its SOP beat until its EOP beat
// is accepted. Beats go out through a single ready/valid output register.
// Beats without SOP that arrive while nobody owns the stream are discarded
// and counted.
//
// state  | meaning
// IDLE   | no owner; arbitrate SOP beats, discard stray non-SOP beats
// GRANT0 | requester 0 owns the stream until its EOP beat is accepted
// GRANT1 | requester 1 owns the stream until its EOP beat is accepted
module ether_tx_arb #(
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [511:0]          in0_data,
    input  logic                  in0_valid,
    input  logic                  in0_sop,
    input  logic                  in0_eop,
    input  logic [7:0]            in0_mty,
    output logic                  in0_ready,
    input  logic [511:0]          in1_data,
    input  logic                  in1_valid,
    input  logic                  in1_sop,
    input  logic                  in1_eop,
    input  logic [7:0]            in1_mty,
    output logic                  in1_ready,
    output logic [511:0]          tx_data,
    output logic                  tx_valid,
    output logic                  tx_sop,
    output logic                  tx_eop,
    output logic [7:0]            tx_mty,
    input  logic                  tx_ready,
    output logic [1:0]            grant,
    output logic [DROP_CNT_W-1:0] drop_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic                last_grant;
    logic                elig0;
    logic                elig1;
    logic                drop0;
    logic                drop1;
    logic                out_free;
    logic                acc0;
    logic                acc1;
    logic [DROP_CNT_W:0] drop_sum;

    assign elig0    = in0_valid && in0_sop;
    assign elig1    = in1_valid && in1_sop;
    assign drop0    = (state == IDLE) && in0_valid && !in0_sop;
    assign drop1    = (state == IDLE) && in1_valid && !in1_sop;
    // The output register can take a beat when empty or draining this cycle.
    assign out_free = !tx_valid || tx_ready;
    assign acc0     = (state == GRANT0) && in0_valid && out_free;
    assign acc1     = (state == GRANT1) && in1_valid && out_free;

    // State register; last_grant remembers who was granted most recently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == GRANT0) begin
                last_grant <= 1'b0;
            end else if (state == IDLE && state_nx == GRANT1) begin
                last_grant <= 1'b1;
            end
        end
    end

    // Next state: round-robin tie-break favours the requester not granted last.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (elig0 && elig1) begin
                    state_nx = last_grant ? GRANT0 : GRANT1;
                end else if (elig0) begin
                    state_nx = GRANT0;
                end else if (elig1) begin
                    state_nx = GRANT1;
                end
            end
            GRANT0: begin
                if (acc0 && in0_eop) begin
                    state_nx = IDLE;
                end
            end
            GRANT1: begin
                if (acc1 && in1_eop) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs: stray beats are swallowed in IDLE, eligible SOPs wait for a grant.
    always_comb begin
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        grant     = 2'b00;
        case (state)
            IDLE: begin
                in0_ready = in0_valid && !in0_sop;
                in1_ready = in1_valid && !in1_sop;
            end
            GRANT0: begin
                in0_ready = out_free;
                grant     = 2'b01;
            end
            GRANT1: begin
                in1_ready = out_free;
                grant     = 2'b10;
            end
            default: begin
                grant = 2'b00;
            end
        endcase
    end

    // Output register: load on accept, clear when drained, hold while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_sop   <= 1'b0;
            tx_eop   <= 1'b0;
            tx_mty   <= '0;
        end else if (acc0) begin
            tx_valid <= 1'b1;
            tx_data  <= in0_data;
            tx_sop   <= in0_sop;
            tx_eop   <= in0_eop;
            tx_mty   <= in0_mty;
        end else if (acc1) begin
            tx_valid <= 1'b1;
            tx_data  <= in1_data;
            tx_sop   <= in1_sop;
            tx_eop   <= in1_eop;
            tx_mty   <= in1_mty;
        end else if (tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

    assign drop_sum = {1'b0, drop_count}
                    + {{DROP_CNT_W{1'b0}}, drop0}
                    + {{DROP_CNT_W{1'b0}}, drop1};

    // Saturating count of discarded beats; carry-out means pin at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop_sum[DROP_CNT_W]) begin
            drop_count <= '1;
        end else begin
            drop_count <= drop_sum[DROP_CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_ether_tx_arb.sv
// Self-checking bench for ether_tx_arb: a per-cycle vector table, directed
// multi-cycle sequences, and a randomized run against a packet-level
// round-robin model.
module tb_ether_tx_arb;
    localparam int DW  = 16;
    localparam int SAT = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [511:0]  in0_data, in1_data, tx_data;
    logic          in0_valid, in0_sop, in0_eop, in0_ready;
    logic          in1_valid, in1_sop, in1_eop, in1_ready;
    logic [7:0]    in0_mty, in1_mty, tx_mty;
    logic          tx_valid, tx_sop, tx_eop, tx_ready;
    logic [1:0]    grant;
    logic [DW-1:0] drop_count;

    always #5 clk = ~clk;

    ether_tx_arb #(.DROP_CNT_W(DW)) dut (
        .clk(clk), .reset(reset),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_sop(in0_sop),
        .in0_eop(in0_eop), .in0_mty(in0_mty), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_sop(in1_sop),
        .in1_eop(in1_eop), .in1_mty(in1_mty), .in1_ready(in1_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_sop(tx_sop),
        .tx_eop(tx_eop), .tx_mty(tx_mty), .tx_ready(tx_ready),
        .grant(grant), .drop_count(drop_count)
    );

    typedef struct {
        logic [511:0] data;
        logic         sop;
        logic         eop;
        logic [7:0]   mty;
    } beat_t;

    // inputs for one cycle, expected ready before the edge, registered outputs after it
    typedef struct {
        logic v0, s0, e0; logic [7:0] m0, t0;
        logic v1, s1, e1; logic [7:0] t1;
        logic tr;
        logic r0, r1;
        logic [1:0] g; logic tv, ts, te; logic [7:0] tm, tt;
        int dc;
    } vec_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t q0[$], q1[$], exp_q[$], out_q[$];
    int    out_cyc[$];
    int    cyc, quiet, stall_lo, stall_hi, stall_seen;
    bit    rand_rdy, bubbles, hold_pend;
    beat_t snap;
    vec_t  tbl[$];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in0_valid = 1'b0; in0_sop = 1'b0; in0_eop = 1'b0; in0_mty = 8'd0; in0_data = '0;
        in1_valid = 1'b0; in1_sop = 1'b0; in1_eop = 1'b0; in1_mty = 8'd0; in1_data = '0;
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        hold_pend = 1'b0;
    endtask

    task automatic add_pkt(input int src, input int len, input bit rmty);
        for (int k = 0; k < len; k++) begin
            beat_t b;
            for (int w = 0; w < 16; w++) b.data[w*32 +: 32] = $urandom();
            b.data[511:504] = 8'(src);
            b.sop = (k == 0);
            b.eop = (k == len - 1);
            if (rmty) b.mty = 8'($urandom_range(0, 63));
            else      b.mty = b.eop ? 8'd10 : 8'd0;
            if (src == 0) q0.push_back(b);
            else          q1.push_back(b);
        end
    endtask

    // Packet-level round robin: whole packets, alternate when both sources have one.
    function automatic void build_expected();
        beat_t c0[$];
        beat_t c1[$];
        beat_t b;
        int    last, pick;
        bit    fin;
        c0 = q0;
        c1 = q1;
        last = 1;
        exp_q.delete();
        while (c0.size() > 0 || c1.size() > 0) begin
            if (c0.size() > 0 && c1.size() > 0) pick = 1 - last;
            else pick = (c0.size() > 0) ? 0 : 1;
            fin = 1'b0;
            while (!fin) begin
                if (pick == 0) begin
                    b = c0.pop_front();
                    fin = b.eop || (c0.size() == 0);
                end else begin
                    b = c1.pop_front();
                    fin = b.eop || (c1.size() == 0);
                end
                exp_q.push_back(b);
            end
            last = pick;
        end
    endfunction

    task automatic step();
        bit    a0, a1;
        beat_t cur;
        beat_t dmy;
        @(negedge clk);
        if (rand_rdy) tx_ready = ($urandom_range(0, 2) != 0);
        else          tx_ready = !(cyc >= stall_lo && cyc < stall_hi);
        if (q0.size() > 0) begin
            in0_data = q0[0].data; in0_sop = q0[0].sop; in0_eop = q0[0].eop; in0_mty = q0[0].mty;
            in0_valid = q0[0].sop || !bubbles || ($urandom_range(0, 3) != 0);
        end else begin
            in0_valid = 1'b0; in0_sop = 1'b0; in0_eop = 1'b0;
        end
        if (q1.size() > 0) begin
            in1_data = q1[0].data; in1_sop = q1[0].sop; in1_eop = q1[0].eop; in1_mty = q1[0].mty;
            in1_valid = q1[0].sop || !bubbles || ($urandom_range(0, 3) != 0);
        end else begin
            in1_valid = 1'b0; in1_sop = 1'b0; in1_eop = 1'b0;
        end
        #1;
        cur.data = tx_data; cur.sop = tx_sop; cur.eop = tx_eop; cur.mty = tx_mty;
        if (hold_pend) begin
            chk("hold_data", tx_data, snap.data);
            chkn("hold_ctl", int'({tx_valid, tx_sop, tx_eop, tx_mty}),
                 int'({1'b1, snap.sop, snap.eop, snap.mty}));
        end
        hold_pend = tx_valid && !tx_ready;
        snap = cur;
        if (tx_valid && !tx_ready) begin
            stall_seen++;
            chkn("stall_ready", int'({in0_ready, in1_ready}), 0);
        end
        a0 = in0_valid && in0_ready;
        a1 = in1_valid && in1_ready;
        if (a0) chkn("grant_in0", int'(grant), 1);
        if (a1) chkn("grant_in1", int'(grant), 2);
        if (tx_valid && tx_ready) begin
            out_q.push_back(cur);
            out_cyc.push_back(cyc);
        end
        quiet = tx_valid ? 0 : quiet + 1;
        @(posedge clk);
        if (a0) dmy = q0.pop_front();
        if (a1) dmy = q1.pop_front();
        cyc++;
    endtask

    task automatic run_engine(input int budget);
        build_expected();
        out_q.delete();
        out_cyc.delete();
        cyc = 0; quiet = 0; hold_pend = 1'b0; stall_seen = 0;
        while (cyc < budget && (q0.size() > 0 || q1.size() > 0 || quiet < 3)) step();
        chkn("engine_done", int'(cyc < budget), 1);
        chkn("beat_count", out_q.size(), exp_q.size());
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("beat%0d_data", i), out_q[i].data, exp_q[i].data);
            chkn($sformatf("beat%0d_ctl", i), int'({out_q[i].sop, out_q[i].eop, out_q[i].mty}),
                 int'({exp_q[i].sop, exp_q[i].eop, exp_q[i].mty}));
        end
        q0.delete();
        q1.delete();
    endtask

    initial begin
        int k;
        reset = 1'b1;
        rand_rdy = 1'b0; bubbles = 1'b0; stall_lo = 0; stall_hi = 0;
        do_reset();
        #1;
        chkn("rst_tx_ctl", int'({tx_valid, tx_sop, tx_eop, tx_mty}), 0);
        chk("rst_tx_data", tx_data, '0);
        chkn("rst_grant", int'(grant), 0);
        chkn("rst_ready", int'({in0_ready, in1_ready}), 0);
        chkn("rst_drop", int'(drop_count), 0);

        //               v0    s0    e0    m0     t0     v1    s1    e1    t1     tr    r0    r1    g      tv    ts    te    tm     tt    dc
        tbl.push_back('{1'b1, 1'b1, 1'b0, 8'd0,  8'hA1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 8'd0,  8'hA1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 8'd0,  8'hA1, 0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'd0,  8'hA2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'd0,  8'hA2, 0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 8'd10, 8'hA3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 8'd10, 8'hA3, 0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 1'b1, 1'b0, 1'b0, 8'hB1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 1});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 1'b1, 1'b0, 1'b0, 8'hB2, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 2});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 1'b1, 1'b0, 1'b0, 8'hB3, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 3});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 3});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'd0,  8'hC1, 1'b1, 1'b0, 1'b0, 8'hC2, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 5});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 1'b1, 1'b1, 1'b1, 8'hD1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 5});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 1'b1, 1'b1, 1'b1, 8'hD1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 8'd0,  8'hD1, 5});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 8'd0,  8'hD1, 5});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 5});

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            in0_valid = tbl[i].v0; in0_sop = tbl[i].s0; in0_eop = tbl[i].e0;
            in0_mty = tbl[i].m0; in0_data = {64{tbl[i].t0}};
            in1_valid = tbl[i].v1; in1_sop = tbl[i].s1; in1_eop = tbl[i].e1;
            in1_mty = 8'd0; in1_data = {64{tbl[i].t1}};
            tx_ready = tbl[i].tr;
            #1;
            chkn($sformatf("v%0d_ready", i), int'({in0_ready, in1_ready}), int'({tbl[i].r0, tbl[i].r1}));
            @(posedge clk);
            #1;
            chkn($sformatf("v%0d_grant", i), int'(grant), int'(tbl[i].g));
            chkn($sformatf("v%0d_tx_valid", i), int'(tx_valid), int'(tbl[i].tv));
            if (tbl[i].tv) begin
                chkn($sformatf("v%0d_tx_ctl", i), int'({tx_sop, tx_eop, tx_mty}),
                     int'({tbl[i].ts, tbl[i].te, tbl[i].tm}));
                chk($sformatf("v%0d_tx_data", i), tx_data, {64{tbl[i].tt}});
            end
            chkn($sformatf("v%0d_drop", i), int'(drop_count), tbl[i].dc);
        end

        // drive drop_count from 5 up to saturation; the final +2 must not wrap
        @(negedge clk);
        in0_valid = 1'b1; in0_sop = 1'b0; in0_eop = 1'b0;
        in1_valid = 1'b1; in1_sop = 1'b0; in1_eop = 1'b0;
        tx_ready = 1'b1;
        repeat ((SAT - 7) / 2) @(posedge clk);
        #1;
        chkn("sat_m2", int'(drop_count), SAT - 2);
        @(negedge clk); in0_valid = 1'b0;
        @(posedge clk); #1;
        chkn("sat_m1", int'(drop_count), SAT - 1);
        @(negedge clk); in0_valid = 1'b1;
        @(posedge clk); #1;
        chkn("sat_hit", int'(drop_count), SAT);
        @(posedge clk); #1;
        chkn("sat_hold", int'(drop_count), SAT);
        @(negedge clk); in0_valid = 1'b0; in1_valid = 1'b0;

        // reset during beat 2 of a 4-beat packet
        @(negedge clk);
        in0_valid = 1'b1; in0_sop = 1'b1; in0_eop = 1'b0; in0_data = {16{32'h1234_5678}};
        @(posedge clk);
        @(posedge clk); #1;
        chkn("pre_reset_tv", int'(tx_valid), 1);
        @(negedge clk);
        in0_sop = 1'b0; in0_data = {16{32'h9abc_def0}};
        reset = 1'b1;
        @(posedge clk); #1;
        chkn("mid_rst_tv", int'(tx_valid), 0);
        chkn("mid_rst_grant", int'(grant), 0);
        chkn("mid_rst_drop", int'(drop_count), 0);
        chk("mid_rst_data", tx_data, '0);
        @(negedge clk);
        reset = 1'b0; in0_valid = 1'b0;
        add_pkt(1, 1, 1'b0);
        add_pkt(1, 2, 1'b0);
        run_engine(200);

        // tie after reset: in0 first, then in1 two cycles after in0's EOP
        do_reset();
        add_pkt(0, 2, 1'b0);
        add_pkt(1, 2, 1'b0);
        run_engine(200);
        if (out_cyc.size() >= 3) begin
            chkn("tie_first_cyc", out_cyc[0], 2);
            chkn("tie_gap", out_cyc[2] - out_cyc[1], 2);
        end

        // six 2-beat packets offered continuously: strict alternation
        do_reset();
        for (int p = 0; p < 6; p++) add_pkt(p % 2, 2, 1'b0);
        run_engine(300);
        k = 0;
        for (int i = 0; i < out_q.size(); i++) begin
            if (out_q[i].sop) begin
                chkn($sformatf("rr_order%0d", k), int'(out_q[i].data[511:504]), k % 2);
                k++;
            end
        end
        chkn("rr_packets", k, 6);

        // four-cycle MAC stall in the middle of a 6-beat packet
        do_reset();
        add_pkt(0, 6, 1'b0);
        stall_lo = 4; stall_hi = 8;
        run_engine(200);
        chkn("stall_cycles", stall_seen, 4);
        stall_lo = 0; stall_hi = 0;

        // random lengths, sources, mty, input bubbles and MAC backpressure
        do_reset();
        rand_rdy = 1'b1; bubbles = 1'b1;
        for (int p = 0; p < 60; p++) add_pkt($urandom_range(0, 1), $urandom_range(1, 5), 1'b1);
        run_engine(4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
